// File: rtl/uart_bus_master_if.sv
// IO bus seen from the serial debug bridge: single-cycle write/read strobes,
// read data returned by the slave one cycle after read_en.
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] adress;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output write_en, read_en, adress, write_data, input read_data);
    modport slave  (input write_en, read_en, adress, write_data, output read_data);
endinterface

// File: rtl/uart_bus_master.sv
// Serial debug bridge: decodes 8N1 command frames ('W' addr data / 'R' addr)
// from the host, performs one IO bus access as master and replies over uart_tx.
module uart_bus_master #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_interface.master io_bus,
    output logic            busy,
    output logic            uart_tx,
    input  logic            uart_rx
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] ACK   = 8'h4B;
    localparam logic [7:0] NACK  = 8'h3F;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] GET_ADDR     = 3'd1;
    localparam logic [2:0] GET_DATA     = 3'd2;
    localparam logic [2:0] BUS_WRITE    = 3'd3;
    localparam logic [2:0] BUS_READ     = 3'd4;
    localparam logic [2:0] READ_CAPTURE = 3'd5;
    localparam logic [2:0] SEND_RESP    = 3'd6;

    // ---------------- RX engine ----------------
    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame receiver: start re-check at half bit, then mid-bit sampling LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_valid <= 1'b1;
                        rx_ferr  <= !rx_sync;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- TX engine ----------------
    logic          tx_load;
    logic [7:0]    tx_byte;
    logic          tx_active;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shreg;
    logic          tx_last;

    assign tx_last = tx_active && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);

    // Serialiser: a load (even on the last stop cycle) starts a new frame at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_tx   <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shreg  <= '1;
        end else if (tx_load) begin
            uart_tx   <= 1'b0;
            tx_shreg  <= {1'b1, tx_byte};
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    uart_tx  <= tx_shreg[0];
                    tx_shreg <= {1'b1, tx_shreg[8:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // ---------------- Command FSM ----------------
    logic [2:0]    state;
    logic          is_read;
    logic [1:0]    byte_cnt;
    logic [31:0]   addr_buf, data_buf;
    logic [31:0]   adr_q, wdata_q;
    logic [23:0]   resp_sh;
    logic [1:0]    resp_left;
    logic [TW-1:0] tmo_cnt;
    logic          in_cmd, tmo_hit, is_op;

    assign in_cmd  = (state == GET_ADDR) || (state == GET_DATA);
    assign tmo_hit = in_cmd && (tmo_cnt == TMO_LAST);
    assign is_op   = (rx_byte == OP_W) || (rx_byte == OP_R);

    assign busy              = (state != IDLE);
    assign io_bus.write_en   = (state == BUS_WRITE);
    assign io_bus.read_en    = (state == BUS_READ);
    assign io_bus.adress     = adr_q;
    assign io_bus.write_data = wdata_q;

    // Which byte (if any) the FSM hands to the serialiser this cycle.
    always_comb begin
        tx_load = 1'b0;
        tx_byte = 8'h00;
        case (state)
            IDLE: if (rx_valid && !rx_ferr && !is_op) begin
                tx_load = 1'b1;
                tx_byte = NACK;
            end
            GET_ADDR, GET_DATA: if (rx_valid && rx_ferr) begin
                tx_load = 1'b1;
                tx_byte = NACK;
            end
            BUS_WRITE: begin
                tx_load = 1'b1;
                tx_byte = ACK;
            end
            READ_CAPTURE: begin
                tx_load = 1'b1;
                tx_byte = io_bus.read_data[7:0];
            end
            SEND_RESP: if (tx_last && resp_left != 2'd0) begin
                tx_load = 1'b1;
                tx_byte = resp_sh[7:0];
            end
            default: ;
        endcase
    end

    // Inactivity counter: only runs while a command is partially received.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 tmo_cnt <= '0;
        else if (rx_valid || !in_cmd) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Command sequencing; bus address/data registers only change at a real access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            is_read   <= 1'b0;
            byte_cnt  <= '0;
            addr_buf  <= '0;
            data_buf  <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            resp_sh   <= '0;
            resp_left <= '0;
        end else begin
            case (state)
                IDLE: if (rx_valid && !rx_ferr) begin
                    if (is_op) begin
                        is_read  <= (rx_byte == OP_R);
                        byte_cnt <= '0;
                        state    <= GET_ADDR;
                    end else begin
                        resp_left <= '0;
                        state     <= SEND_RESP;
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            resp_left <= '0;
                            state     <= SEND_RESP;
                        end else begin
                            addr_buf <= {rx_byte, addr_buf[31:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                if (is_read) begin
                                    adr_q <= {rx_byte, addr_buf[31:8]};
                                    state <= BUS_READ;
                                end else begin
                                    state <= GET_DATA;
                                end
                            end
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            resp_left <= '0;
                            state     <= SEND_RESP;
                        end else begin
                            data_buf <= {rx_byte, data_buf[31:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                adr_q   <= addr_buf;
                                wdata_q <= {rx_byte, data_buf[31:8]};
                                state   <= BUS_WRITE;
                            end
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                BUS_WRITE: begin
                    resp_left <= '0;
                    state     <= SEND_RESP;
                end
                BUS_READ: state <= READ_CAPTURE;
                READ_CAPTURE: begin
                    resp_sh   <= io_bus.read_data[31:8];
                    resp_left <= 2'd3;
                    state     <= SEND_RESP;
                end
                SEND_RESP: if (tx_last) begin
                    if (resp_left != 2'd0) begin
                        resp_sh   <= {8'h00, resp_sh[23:8]};
                        resp_left <= resp_left - 2'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus accesses
// and reply bytes; one negedge monitor decodes the bus and uart_tx and compares.
module tb_uart_bus_master;
    localparam int CPB = 16;
    localparam int TMO = 500;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_rx;
    logic uart_tx;
    logic busy;
    logic [31:0] slave_val;

    io_bus_interface io();

    uart_bus_master #(.CLOCKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .io_bus  (io),
        .busy    (busy),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    // Slave: read data valid the cycle after read_en, zero otherwise.
    always @(posedge clk) io.read_data <= io.read_en ? slave_val : 32'h0;

    typedef struct {
        bit          rd;
        logic [31:0] adr;
        logic [31:0] wd;
    } bus_exp_t;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] cmd[$];
    int total = 0;
    int bad   = 0;

    // Monitor: bus strobes and a mid-bit UART decoder on uart_tx.
    bit         tm_act = 1'b0;
    int         tm_cnt = 0;
    logic [7:0] tm_byte;
    always @(negedge clk) begin
        bus_exp_t   e;
        logic [7:0] x;
        if (rst_n && (io.write_en || io.read_en)) begin
            total++;
            if (exp_bus.size() == 0) begin
                bad++;
                $display("FAIL bus_access: got we=%0b re=%0b adr=%h wd=%h, required none",
                         io.write_en, io.read_en, io.adress, io.write_data);
            end else begin
                e = exp_bus.pop_front();
                if (io.write_en !== !e.rd || io.read_en !== e.rd ||
                    io.adress !== e.adr || io.write_data !== e.wd) begin
                    bad++;
                    $display("FAIL bus_access: got we=%0b re=%0b adr=%h wd=%h, required rd=%0b adr=%h wd=%h",
                             io.write_en, io.read_en, io.adress, io.write_data, e.rd, e.adr, e.wd);
                end
            end
        end
        if (!rst_n) begin
            tm_act = 1'b0;
        end else if (!tm_act) begin
            if (!uart_tx) begin
                tm_act = 1'b1;
                tm_cnt = 0;
            end
        end else begin
            tm_cnt++;
            if (tm_cnt % CPB == CPB / 2) begin
                if (tm_cnt / CPB >= 1 && tm_cnt / CPB <= 8) begin
                    tm_byte[tm_cnt / CPB - 1] = uart_tx;
                end else if (tm_cnt / CPB == 9) begin
                    tm_act = 1'b0;
                    total++;
                    if (exp_tx.size() == 0) begin
                        bad++;
                        $display("FAIL tx_byte: got %h, required no reply", tm_byte);
                    end else begin
                        x = exp_tx.pop_front();
                        if (tm_byte !== x || uart_tx !== 1'b1) begin
                            bad++;
                            $display("FAIL tx_byte: got %h stop=%0b, required %h stop=1",
                                     tm_byte, uart_tx, x);
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_cmd();
        for (int i = 0; i < cmd.size(); i++) send_byte(cmd[i], 1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Waits (bounded) for the command to finish and every expectation to be consumed.
    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s: timed out busy=%0b pending_tx=%0d pending_bus=%0d, required idle",
                     name, busy, exp_tx.size(), exp_bus.size());
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        slave_val = 32'h0;
        repeat (5) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_write_en", {31'd0, io.write_en}, 32'd0);
        check("rst_read_en", {31'd0, io.read_en}, 32'd0);
        check("rst_adress", io.adress, 32'h0);
        check("rst_write_data", io.write_data, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: write
        exp_bus.push_back('{1'b0, 32'hF0000010, 32'hDEADBEEF});
        exp_tx.push_back(8'h4B);
        cmd = '{8'h57, 8'h10, 8'h00, 8'h00, 8'hF0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_cmd();
        wait_done("t1_write");

        // 2: read, write_data keeps the last write value
        slave_val = 32'h12345678;
        exp_bus.push_back('{1'b1, 32'hF0000004, 32'hDEADBEEF});
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        cmd = '{8'h52, 8'h04, 8'h00, 8'h00, 8'hF0};
        send_cmd();
        wait_done("t2_read");

        // 3: unknown opcode
        exp_tx.push_back(8'h3F);
        send_byte(8'h00, 1'b1);
        wait_done("t3_unknown");

        // 4: frame error on 3rd byte, then a good write
        exp_tx.push_back(8'h3F);
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b0);
        wait_done("t4_frame_err");
        exp_bus.push_back('{1'b0, 32'hF0000020, 32'h12345678});
        exp_tx.push_back(8'h4B);
        cmd = '{8'h57, 8'h20, 8'h00, 8'h00, 8'hF0, 8'h78, 8'h56, 8'h34, 8'h12};
        send_cmd();
        wait_done("t4_write_after");

        // 5: partial read then silence -> silent abort after TMO cycles
        send_byte(8'h52, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (480) @(negedge clk);
        check("t5_busy_before_tmo", {31'd0, busy}, 32'd1);
        repeat (30) @(negedge clk);
        check("t5_busy_after_tmo", {31'd0, busy}, 32'd0);
        wait_done("t5_quiet");

        // 6: reset during the 2nd reply byte, then a 1-cycle rx glitch
        slave_val = 32'hCAFEF00D;
        exp_bus.push_back('{1'b1, 32'hF0000008, 32'h12345678});
        exp_tx.push_back(8'h0D);
        cmd = '{8'h52, 8'h08, 8'h00, 8'h00, 8'hF0};
        send_cmd();
        n = 0;
        while (exp_tx.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_byte_wait", n < 3000 ? 32'd1 : 32'd0, 32'd1);
        repeat (24) @(negedge clk);
        check("t6_tx_low_before_rst", {31'd0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_adress", io.adress, 32'h0);
        check("t6_rst_write_data", io.write_data, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (busy || !uart_tx) seen = 1'b1;
        end
        check("t6_glitch_ignored", {31'd0, seen}, 32'd0);
        wait_done("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
